// File: rtl/control_step_sequencer.sv
// -----------------------------------------------------------------------------
// control_step_sequencer
//
// Control-step generator for the RISC datapath. It walks through the fetch
// steps T0..T2 and the per-class execute steps T3..T7 and decodes the
// DataPath control strobes from the current step and opcode. Memory steps
// (fetch T1, LD T6, ST T7) stall until mem_ready. A stall that lasts too long
// parks the sequencer in a sticky FAULT state that only clear can leave.
//
// Ports
//   clock, clear          : rising-edge clock, asynchronous active-high reset
//   run                   : level, high = keep fetching/executing
//   ir_opcode [OPW]       : opcode field of the IR (decoded live in T3)
//   mem_ready             : memory completion for the Read/Write steps
//   PCout..Cout           : bus drive strobes
//   MARin..Rin            : register load strobes
//   IncPC, Read, Write    : PC increment and memory strobes
//   Gra, Grb, Grc         : register-field selects
//   alu_op [ALU_OP_W]     : ALU operation (ADD = 3)
//   step [4]              : IDLE=0, T0..T7=1..8, FAULT=15
//   busy                  : high in T0..T7
//   instr_done            : pulse in the final step of each instruction
//   mem_fault             : sticky memory timeout flag
// -----------------------------------------------------------------------------
module control_step_sequencer #(
    parameter int OPW          = 5,
    parameter int ALU_OP_W     = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [OPW-1:0]      ir_opcode,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                Rout,
    output logic                BAout,
    output logic                Cout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                Rin,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          step,
    output logic                busy,
    output logic                instr_done,
    output logic                mem_fault
);
    // Opcodes are zero-extended to at least 4 bits so ADDI (12) is decodable.
    localparam int EXT_W  = (OPW > 4) ? OPW : 4;
    localparam int WCNT_W = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_FAULT = 4'd15
    } state_t;

    typedef enum logic [2:0] {C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_NONE} class_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3);

    function automatic class_t classify(input logic [EXT_W-1:0] op);
        case (int'(op))
            0:          return C_LD;
            1:          return C_LDI;
            2:          return C_ST;
            3, 4, 5, 6: return C_ALU;
            12:         return C_ADDI;
            default:    return C_NONE;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_q, wait_d;
    logic [EXT_W-1:0]    opcode_q, opcode_d;

    logic [EXT_W-1:0]    op_live;
    logic [EXT_W-1:0]    cur_op;
    class_t              cls;
    logic                is_mem;
    logic                is_final;

    assign op_live = EXT_W'(ir_opcode);
    // T3 decodes the IR directly; later steps use the copy latched leaving T3.
    assign cur_op  = (state_q == S_T3) ? op_live : opcode_q;
    assign cls     = classify(cur_op);

    // Strobe decode of the registered step
    always_comb begin
        {PCout, Zlowout, MDRout, Rout, BAout, Cout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc} = '0;
        alu_op   = '0;
        is_mem   = 1'b0;
        is_final = 1'b0;
        case (state_q)
            S_T0: {PCout, MARin, IncPC, ZLowIn} = '1;
            S_T1: begin
                {Zlowout, PCin, Read, MDRin} = '1;
                is_mem = 1'b1;
            end
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                case (cls)
                    C_LD, C_LDI, C_ST: {Grb, BAout, Yin} = '1;
                    C_ALU, C_ADDI:     {Grb, Rout, Yin} = '1;
                    default:           is_final = 1'b1;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU: begin
                        {Grc, Rout, ZLowIn} = '1;
                        alu_op = ALU_OP_W'(cur_op);
                    end
                    default: begin
                        {Cout, ZLowIn} = '1;
                        alu_op = ALU_ADD;
                    end
                endcase
            end
            S_T5: begin
                if (cls == C_LD || cls == C_ST) begin
                    {Zlowout, MARin} = '1;
                end else begin
                    {Zlowout, Gra, Rin} = '1;
                    is_final = 1'b1;
                end
            end
            S_T6: begin
                if (cls == C_ST) begin
                    {Gra, Rout, MDRin} = '1;
                end else begin
                    {Read, MDRin} = '1;
                    is_mem = 1'b1;
                end
            end
            S_T7: begin
                is_final = 1'b1;
                if (cls == C_ST) begin
                    Write  = 1'b1;
                    is_mem = 1'b1;
                end else begin
                    {MDRout, Gra, Rin} = '1;
                end
            end
            default: ;
        endcase
    end

    assign step       = state_q;
    assign busy       = (state_q >= S_T0) && (state_q <= S_T7);
    assign mem_fault  = (state_q == S_FAULT);
    // A memory final step only completes in the cycle mem_ready is seen.
    assign instr_done = is_final && (!is_mem || mem_ready);

    // Next-step selection
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        opcode_d = opcode_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_T0;
            S_FAULT: state_d = S_FAULT;
            default: begin
                if (is_mem && !mem_ready) begin
                    // mem_ready wins over the timeout on the limit edge.
                    if (wait_q == WCNT_W'(MEM_WAIT_MAX - 1)) begin
                        state_d = S_FAULT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WCNT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                    if (state_q == S_T3) opcode_d = op_live;
                    if (is_final) state_d = run ? S_T0 : S_IDLE;
                    else          state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            opcode_q <= opcode_d;
        end
    end
endmodule

// File: doc/control_step_sequencer.md
Name: control_step_sequencer

Overview:
- Hardware control-step generator for the RISC datapath. It drives the DataPath control strobes for fetch (T0–T2) and execute (T3–T7) for load, load-immediate, store, register ALU and immediate ALU classes.
- Adds memory wait-states with a timeout fault, a run/stop control and per-class step lengths.
- Sits between the IR opcode field and the DataPath control inputs.

Parameters:
- OPW, 5, opcode width; the opcode is zero-extended internally for decode.
- ALU_OP_W, 5, width of the alu_op output.
- MEM_WAIT_MAX, 15, maximum consecutive cycles with mem_ready low in a memory step before fault; must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- run  in  1  level; high = fetch/execute continuously.
- ir_opcode  in  OPW  opcode field of IR.
- mem_ready  in  1  memory completion for Read/Write steps.
- PCout, Zlowout, MDRout, Rout, BAout, Cout  out  1 each  bus drive strobes.
- MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin  out  1 each  register load strobes.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- Gra, Grb, Grc  out  1 each  register-field selects.
- alu_op  out  ALU_OP_W  ALU operation; ADD=5'b00011.
- step  out  4  IDLE=0, T0..T7=1..8, FAULT=15.
- busy  out  1  high in T0..T7.
- instr_done  out  1  one-cycle pulse in the final step of each instruction.
- mem_fault  out  1  sticky timeout flag.

Behaviour:
- clear asserted (any time, including mid-instruction): state=IDLE, wait counter=0, latched opcode=0, mem_fault=0. All strobes, alu_op, busy, instr_done and step are 0 immediately.
- Outputs are combinational decode of the registered state, plus the latched opcode (T4–T7) or ir_opcode (T3). IDLE and FAULT drive all strobes 0.
- IDLE→T0 on the first edge with run=1.
- The final step of an instruction goes to T0 if run=1, else IDLE. run low mid-instruction never truncates the instruction.
- Opcode is latched on the edge leaving T3.

Fetch:
- T0: PCout, MARin, IncPC, ZLowIn.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.

Execute by opcode (ALU ops: ADD=3, SUB=4, AND=5, OR=6):
- LD (0):
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_op=ADD, ZLowIn.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin; done.
- LDI (1): T3/T4 as LD; T5: Zlowout, Gra, Rin; done.
- ST (2):
  - T3–T5 as LD.
  - T6: Gra, Rout, MDRin.
  - T7: Write; done.
- ALU reg (3–6):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op=opcode, ZLowIn.
  - T5: Zlowout, Gra, Rin; done.
- ADDI (12):
  - T3: Grb, Rout, Yin.
  - T4: Cout, alu_op=ADD, ZLowIn.
  - T5 as ALU reg; done.
- Any other opcode: T3 drives nothing; T3 is the final step.

Memory steps (T1, LD T6, ST T7):
- The state advances only on an edge with mem_ready=1; strobes stay asserted while held.
- The wait counter increments each cycle the step is held with mem_ready=0 and resets on step exit.
- If mem_ready=0 for MEM_WAIT_MAX consecutive cycles, the next edge enters FAULT.
- mem_ready=1 on the same edge the counter reaches its limit means advance, not fault.
- FAULT: mem_fault=1, step=15; it is left only by clear. run is ignored there.
- instr_done is asserted during the final-step cycle. On a memory final step it is asserted only in the cycle mem_ready=1.
- alu_op=0 in every step not listed above.

Test Plan:
- Reset: clear pulsed mid-T4 of an ADD → all outputs 0 within the same cycle, step=0, and IDLE is held while run=0.
- LD, mem_ready tied 1, run=1, ir_opcode=0 → steps 1..8 on consecutive cycles with the exact strobes above. T4 alu_op=3. instr_done high only at step=8, then step=1.
- Wait states: LD with mem_ready low 3 cycles in T1 and 2 cycles in T6 → T1 held 4 cycles and T6 held 3 cycles with Read/MDRin steady. Total 13 cycles T0→T7.
- ST then ADD (opcode 3) back to back, run dropped during ADD T4 → ST T6 drives Gra/Rout/MDRin, T7 drives Write. ADD T4 drives Grc/Rout/ZLowIn with alu_op=3. The sequencer returns to IDLE after ADD T5.
- Timeout with MEM_WAIT_MAX=4: mem_ready held 0 in T1 → FAULT after 4 held cycles, mem_fault=1, step=15, strobes 0. It remains there until clear.
- Opcode 31 → T0..T3 then T0, instr_done at T3, no execute strobes. ADDI (12) → T4 Cout with alu_op=3, done at T5.
